clock12_timekeeper: RTL and testbench
=====================================

Name: clock12_timekeeper

Overview:
- Free-running 12-hour wall-clock counter directly downstream of the 12-hour time-setting FSM.
- Loads the user-set AM/PM, hour and minute values when the setter's propagate level rises.
- Advances the time once per second from an internal clock prescaler.
- Drives the display and alarm logic with the current time, a top-of-hour strobe and a time-valid flag.

Parameters:
- TICK_DIV, 50000000: clk cycles per second; legal range 2..2^PRESCALE_W.
- PRESCALE_W, 26: prescaler counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  setter's propagate level; a 0->1 edge loads a new time.
- load_is_pm  input  1  setter's AM/PM value (1 = PM).
- load_hours  input  4  setter's hour value.
- load_minutes  input  6  setter's minute value.
- is_pm  output  1  current AM/PM (1 = PM).
- hours  output  4  current hour, 1..12.
- minutes  output  6  current minute, 0..59.
- seconds  output  6  current second, 0..59.
- sec_pulse  output  1  one-cycle pulse on each seconds advance.
- hour_strobe  output  1  one-cycle pulse when minutes wraps 59->0.
- time_valid  output  1  high once a time has been loaded since reset.

Behaviour:
- Reset values (reset high on an edge): is_pm=0, hours=12, minutes=0, seconds=0, sec_pulse=0, hour_strobe=0, time_valid=0, prescaler=0.
  - During reset, load_q <= load, so a load held high through reset does not trigger a load.
- Edge detect:
  - load_q <= load every cycle.
  - load_edge = load & ~load_q.
  - A held-high load (the setter leaves propagate at 1 after finishing) loads exactly once.
- Load (load_edge=1):
  - Next edge: is_pm <= load_is_pm, seconds <= 0, prescaler <= 0, time_valid <= 1, sec_pulse <= 0, hour_strobe <= 0.
  - Hours sanitising: load_hours 0 -> 12; values >12 -> 12; otherwise copied.
  - Minutes sanitising: load_minutes >59 -> 0; otherwise copied.
  - Load has priority over a tick in the same cycle; that tick is discarded.
- Prescaler:
  - Increments every cycle.
  - tick = (prescaler == TICK_DIV-1); on tick, prescaler <= 0.
  - Counting runs regardless of time_valid.
- On tick (no load_edge), state advances in the same edge, with registered outputs:
  - sec_pulse=1 for exactly that cycle.
  - seconds 0..58 -> +1.
  - seconds 59 -> 0 and minute carry.
- Minute carry:
  - minutes 0..58 -> +1.
  - minutes 59 -> 0, hour carry, and hour_strobe=1 for that cycle.
- Hour carry:
  - hours 12 -> 1.
  - hours 11 -> 12 and is_pm toggles (11:59:59 PM -> 12:00:00 AM; 11:59:59 AM -> 12:00:00 PM).
  - Other hours -> +1.
- sec_pulse and hour_strobe are 0 on every cycle without a tick.
- Latency:
  - Outputs reflect a load one cycle after the load edge is sampled.
  - The first sec_pulse after a load occurs TICK_DIV cycles after the loading edge.
- Reset mid-count overrides load and tick; time returns to 12:00:00 AM and time_valid=0.

Test Plan:
- TICK_DIV=4; reset 2 cycles -> 12:00:00 AM, time_valid=0, no pulses; after 4 cycles seconds=1 and one sec_pulse.
- Load 0->1 with (PM=1, 11, 59), then hold load=1 for 500 cycles -> exactly one load; shows 11:59:00 PM, time_valid=1; after 60 ticks shows 12:00:00 AM with one hour_strobe and is_pm=0.
- Load (0, 12, 59), advance 60 ticks -> 1:00:00 AM, is_pm unchanged, hour_strobe pulses once.
- Load hours=0, minutes=63 -> hours=12, minutes=0, seconds=0.
- Drive the load edge on the exact cycle prescaler==3 -> loaded value shown, no sec_pulse, next sec_pulse 4 cycles later.
- Assert reset at 5:23:41 PM with load held at 1, then release -> 12:00:00 AM, time_valid=0, no reload until load drops and rises again.

Source files
------------

// File: rtl/clock12_timekeeper.sv
// 12-hour wall-clock timekeeper.
// Loads a user-set time on the rising edge of the setter's propagate level.
// Advances once per second from an internal prescaler.
// Publishes the current time, a per-second pulse, a top-of-hour strobe and a valid flag.
module clock12_timekeeper #(
  parameter int TICK_DIV   = 50000000,
  parameter int PRESCALE_W = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       load_is_pm,
  input  logic [3:0] load_hours,
  input  logic [5:0] load_minutes,
  output logic       is_pm,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_pulse,
  output logic       hour_strobe,
  output logic       time_valid
);

  // Last prescaler count of each second; reaching it produces a tick.
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE   = PRESCALE_W'(1);

  // Out-of-range hours (0 or above 12) fall back to 12.
  function automatic logic [3:0] sanitize_hours(input logic [3:0] h);
    logic [3:0] r;
    if ((h == 4'd0) || (h > 4'd12)) begin
      r = 4'd12;
    end else begin
      r = h;
    end
    return r;
  endfunction

  // Out-of-range minutes (above 59) fall back to 0.
  function automatic logic [5:0] sanitize_minutes(input logic [5:0] m);
    logic [5:0] r;
    if (m > 6'd59) begin
      r = 6'd0;
    end else begin
      r = m;
    end
    return r;
  endfunction

  logic [PRESCALE_W-1:0] prescale_r;
  logic                  load_q_r;
  logic                  load_edge_s;
  logic                  tick_s;
  logic [5:0]            sec_next_s;
  logic [5:0]            min_next_s;
  logic [3:0]            hr_next_s;
  logic                  pm_next_s;
  logic                  strobe_next_s;

  assign load_edge_s = load & ~load_q_r;
  assign tick_s      = (prescale_r == TICK_LAST);

  // Compute the time one second after the current time, with carries.
  always_comb begin
    sec_next_s    = seconds;
    min_next_s    = minutes;
    hr_next_s     = hours;
    pm_next_s     = is_pm;
    strobe_next_s = 1'b0;
    if (seconds == 6'd59) begin
      sec_next_s = 6'd0;
      if (minutes == 6'd59) begin
        min_next_s    = 6'd0;
        strobe_next_s = 1'b1;
        case (hours)
          4'd12: begin
            hr_next_s = 4'd1;
          end
          4'd11: begin
            // 11 -> 12 is where AM and PM swap.
            hr_next_s = 4'd12;
            pm_next_s = ~is_pm;
          end
          default: begin
            hr_next_s = hours + 4'd1;
          end
        endcase
      end else begin
        min_next_s = minutes + 6'd1;
      end
    end else begin
      sec_next_s = seconds + 6'd1;
    end
  end

  // Edge detector, prescaler and time registers; a load wins over a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Track load during reset so a level held high through reset does not load.
      load_q_r    <= load;
      prescale_r  <= '0;
      is_pm       <= 1'b0;
      hours       <= 4'd12;
      minutes     <= 6'd0;
      seconds     <= 6'd0;
      sec_pulse   <= 1'b0;
      hour_strobe <= 1'b0;
      time_valid  <= 1'b0;
    end else begin
      load_q_r <= load;
      if (load_edge_s) begin
        prescale_r  <= '0;
        is_pm       <= load_is_pm;
        hours       <= sanitize_hours(load_hours);
        minutes     <= sanitize_minutes(load_minutes);
        seconds     <= 6'd0;
        sec_pulse   <= 1'b0;
        hour_strobe <= 1'b0;
        time_valid  <= 1'b1;
      end else if (tick_s) begin
        prescale_r  <= '0;
        is_pm       <= pm_next_s;
        hours       <= hr_next_s;
        minutes     <= min_next_s;
        seconds     <= sec_next_s;
        sec_pulse   <= 1'b1;
        hour_strobe <= strobe_next_s;
      end else begin
        prescale_r  <= prescale_r + PRE_ONE;
        sec_pulse   <= 1'b0;
        hour_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock12_timekeeper.sv
// Self-checking bench for clock12_timekeeper with a seconds-of-day reference model.
module tb_clock12_timekeeper;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       load_is_pm;
  logic [3:0] load_hours;
  logic [5:0] load_minutes;
  logic       is_pm;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_pulse;
  logic       hour_strobe;
  logic       time_valid;

  clock12_timekeeper #(.TICK_DIV(TD), .PRESCALE_W(26)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_is_pm   (load_is_pm),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .is_pm        (is_pm),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .sec_pulse    (sec_pulse),
    .hour_strobe  (hour_strobe),
    .time_valid   (time_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time as seconds since midnight, plus cycle phase within a second.
  int m_day    = 0;
  int m_phase  = 0;
  int m_valid  = 0;
  int m_sp     = 0;
  int m_hs     = 0;
  int m_load_q = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_day(input int pm, input int h, input int m);
    int hh;
    int mm;
    hh = (h == 0 || h > 12) ? 12 : h;
    mm = (m > 59) ? 0 : m;
    return ((hh % 12) + (pm != 0 ? 12 : 0)) * 3600 + mm * 60;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int edge_v;
    if (reset) begin
      m_day = 0; m_phase = 0; m_valid = 0; m_sp = 0; m_hs = 0;
      m_load_q = int'(load);
    end else begin
      edge_v   = (load == 1'b1 && m_load_q == 0) ? 1 : 0;
      m_load_q = int'(load);
      if (edge_v != 0) begin
        m_day   = to_day(int'(load_is_pm), int'(load_hours), int'(load_minutes));
        m_phase = 0; m_valid = 1; m_sp = 0; m_hs = 0;
      end else if (m_phase == TD - 1) begin
        m_phase = 0;
        m_day   = (m_day + 1) % 86400;
        m_sp    = 1;
        m_hs    = (m_day % 3600 == 0) ? 1 : 0;
      end else begin
        m_phase++;
        m_sp = 0; m_hs = 0;
      end
    end
  endtask

  task automatic compare_all();
    int h24;
    h24 = m_day / 3600;
    check("is_pm",       int'(is_pm),       (h24 >= 12) ? 1 : 0);
    check("hours",       int'(hours),       (h24 % 12 == 0) ? 12 : h24 % 12);
    check("minutes",     int'(minutes),     (m_day / 60) % 60);
    check("seconds",     int'(seconds),     m_day % 60);
    check("sec_pulse",   int'(sec_pulse),   m_sp);
    check("hour_strobe", int'(hour_strobe), m_hs);
    check("time_valid",  int'(time_valid),  m_valid);
  endtask

  // One clock: update model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_load(input int pm, input int h, input int m);
    load_is_pm   = 1'(pm);
    load_hours   = 4'(h);
    load_minutes = 6'(m);
    load         = 1'b1;
  endtask

  initial begin
    int strobes;
    int found;
    reset = 1'b1; load = 1'b0; load_is_pm = 1'b0; load_hours = 4'd0; load_minutes = 6'd0;
    @(negedge clk);
    step(); step();
    check("rst_hours", int'(hours), 12);
    check("rst_valid", int'(time_valid), 0);
    check("rst_pulse", int'(sec_pulse), 0);
    reset = 1'b0;
    repeat (4) step();
    check("first_sec", int'(seconds), 1);
    check("first_pulse", int'(sec_pulse), 1);

    // 11:59 PM load with load held high for 500 cycles: one load, crosses midnight once.
    set_load(1, 11, 59);
    step();
    check("ld_hours", int'(hours), 11);
    check("ld_min", int'(minutes), 59);
    check("ld_pm", int'(is_pm), 1);
    check("ld_valid", int'(time_valid), 1);
    strobes = 0;
    for (int i = 0; i < 499; i++) begin
      step();
      if (hour_strobe) strobes++;
    end
    check("midnight_strobes", strobes, 1);
    check("midnight_pm", int'(is_pm), 0);
    check("midnight_hours", int'(hours), 12);
    check("midnight_min", int'(minutes), 1);
    check("midnight_sec", int'(seconds), 4);
    load = 1'b0; step();

    // 12:59 AM -> 1:00 AM.
    set_load(0, 12, 59);
    step();
    strobes = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (hour_strobe) strobes++;
    end
    check("one_am_hours", int'(hours), 1);
    check("one_am_min", int'(minutes), 0);
    check("one_am_pm", int'(is_pm), 0);
    check("one_am_strobes", strobes, 1);
    load = 1'b0; step();

    // 11:59 AM -> 12:00 PM.
    set_load(0, 11, 59);
    step();
    repeat (240) step();
    check("noon_hours", int'(hours), 12);
    check("noon_pm", int'(is_pm), 1);
    load = 1'b0; step();

    // Sanitising of out-of-range values.
    set_load(1, 0, 63);
    step();
    check("san_hours", int'(hours), 12);
    check("san_min", int'(minutes), 0);
    check("san_sec", int'(seconds), 0);
    load = 1'b0; step();
    set_load(0, 14, 60);
    step();
    check("san_hours_hi", int'(hours), 12);
    check("san_min_60", int'(minutes), 0);
    load = 1'b0; step();

    // Load coinciding with a tick: tick discarded, next pulse TD cycles later.
    found = 0;
    for (int i = 0; i < 2 * TD && found == 0; i++) begin
      if (m_phase == TD - 1) found = 1;
      else step();
    end
    check("align_found", found, 1);
    set_load(0, 7, 30);
    step();
    check("coll_pulse", int'(sec_pulse), 0);
    check("coll_sec", int'(seconds), 0);
    check("coll_min", int'(minutes), 30);
    for (int i = 0; i < TD - 1; i++) begin
      step();
      check("coll_nopulse", int'(sec_pulse), 0);
    end
    step();
    check("coll_next_pulse", int'(sec_pulse), 1);
    load = 1'b0; step();

    // Reset at 5:23:41 PM with load held high.
    set_load(1, 5, 23);
    step();
    repeat (41 * TD) step();
    check("pre_rst_sec", int'(seconds), 41);
    check("pre_rst_hours", int'(hours), 5);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (20) step();
    check("post_rst_valid", int'(time_valid), 0);
    check("post_rst_hours", int'(hours), 12);
    check("post_rst_pm", int'(is_pm), 0);
    load = 1'b0; step();
    load = 1'b1; step();
    check("reload_valid", int'(time_valid), 1);
    check("reload_hours", int'(hours), 5);
    check("reload_pm", int'(is_pm), 1);
    load = 1'b0; step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        load = ~load;
        if (load) begin
          load_is_pm   = 1'($urandom_range(0, 1));
          load_hours   = 4'($urandom_range(0, 15));
          load_minutes = 6'($urandom_range(0, 63));
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
